// File: rtl/pipelined_decode_pkg.sv
// Shared definitions for the pipelined LEGv8 decode stage: opcodes, ALU op
// classes, the control bundle and the decode/immediate helper functions.
package pipelined_decode_pkg;

  localparam int INSTR_LEN = 32;
  localparam int OPC_W     = 11;
  localparam int IMM_W     = 64;

  localparam logic [10:0] OP_ADD    = 11'b10001011000;
  localparam logic [10:0] OP_SUB    = 11'b11001011000;
  localparam logic [10:0] OP_AND    = 11'b10001010000;
  localparam logic [10:0] OP_ORR    = 11'b10101010000;
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI_P = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI_P = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ_P  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ_P = 8'b10110101;
  localparam logic [5:0]  OP_B_P    = 6'b000101;

  localparam logic [1:0] ALU_OP_MEM = 2'b00;
  localparam logic [1:0] ALU_OP_CB  = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_R, CLS_I, CLS_LD, CLS_ST, CLS_CBZ, CLS_CBNZ, CLS_B
  } instr_cls_e;

  typedef struct packed {
    logic       branch;
    logic       cbz;
    logic       cbnz;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_ZERO = '0;

  function automatic instr_cls_e classify(input logic [OPC_W-1:0] opc);
    instr_cls_e cls;
    cls = CLS_NONE;
    if (opc == OP_ADD || opc == OP_SUB || opc == OP_AND || opc == OP_ORR) cls = CLS_R;
    else if (opc[10:1] == OP_ADDI_P || opc[10:1] == OP_SUBI_P)          cls = CLS_I;
    else if (opc == OP_LDUR)                                            cls = CLS_LD;
    else if (opc == OP_STUR)                                            cls = CLS_ST;
    else if (opc[10:3] == OP_CBZ_P)                                     cls = CLS_CBZ;
    else if (opc[10:3] == OP_CBNZ_P)                                    cls = CLS_CBNZ;
    else if (opc[10:5] == OP_B_P)                                       cls = CLS_B;
    return cls;
  endfunction

  function automatic ctrl_t decode_ctrl(input instr_cls_e cls);
    ctrl_t c;
    c = CTRL_ZERO;
    case (cls)
      CLS_R:    begin c.reg_write = 1'b1; c.alu_op = ALU_OP_R; end
      CLS_I:    begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OP_R; end
      CLS_LD:   begin
        c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1;
        c.alu_op = ALU_OP_MEM;
      end
      CLS_ST:   begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_OP_MEM; end
      CLS_CBZ:  begin c.cbz = 1'b1; c.alu_op = ALU_OP_CB; end
      CLS_CBNZ: begin c.cbnz = 1'b1; c.alu_op = ALU_OP_CB; end
      CLS_B:    c.branch = 1'b1;
      default:  c = CTRL_ZERO;
    endcase
    return c;
  endfunction

  function automatic logic [IMM_W-1:0] imm_extend(input logic [INSTR_LEN-1:0] instr,
                                                  input instr_cls_e cls);
    logic [IMM_W-1:0] imm;
    imm = '0;
    case (cls)
      CLS_LD, CLS_ST:    imm = {{55{instr[20]}}, instr[20:12]};
      CLS_I:             imm = {52'd0, instr[21:10]};
      CLS_CBZ, CLS_CBNZ: imm = {{45{instr[23]}}, instr[23:5]};
      CLS_B:             imm = {{38{instr[25]}}, instr[25:0]};
      default:           imm = '0;
    endcase
    return imm;
  endfunction

  // Stores and compare-and-branch read their Rt (rd field) on the second port.
  function automatic logic rr2_is_rd(input instr_cls_e cls);
    return (cls == CLS_ST) || (cls == CLS_CBZ) || (cls == CLS_CBNZ);
  endfunction

  function automatic logic uses_rr2(input instr_cls_e cls);
    return (cls == CLS_R) || rr2_is_rd(cls);
  endfunction

endpackage

// File: rtl/pipelined_decode_regfile.sv
// Two-read/one-write register file for the decode stage; ZERO_REG reads as zero
// and swallows writes, and BYPASS forwards a same-cycle write to the read ports.
module decode_regfile #(
  parameter int WORD     = 64,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rd_addr1_i,
  input  logic [REG_AW-1:0] rd_addr2_i,
  output logic [WORD-1:0]   rd_data1_o,
  output logic [WORD-1:0]   rd_data2_o,
  input  logic              wr_en_i,
  input  logic [REG_AW-1:0] wr_addr_i,
  input  logic [WORD-1:0]   wr_data_i
);
  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  logic [WORD-1:0] regs_q [NUM_REGS];
  logic            wr_ok;

  function automatic logic addr_ok(input logic [REG_AW-1:0] a);
    return (a != ZR) && (int'(a) < NUM_REGS);
  endfunction

  assign wr_ok = wr_en_i && addr_ok(wr_addr_i);

  always_comb begin
    rd_data1_o = '0;
    if (addr_ok(rd_addr1_i)) begin
      if ((BYPASS != 0) && wr_ok && (wr_addr_i == rd_addr1_i)) rd_data1_o = wr_data_i;
      else                                                     rd_data1_o = regs_q[rd_addr1_i];
    end
  end

  always_comb begin
    rd_data2_o = '0;
    if (addr_ok(rd_addr2_i)) begin
      if ((BYPASS != 0) && wr_ok && (wr_addr_i == rd_addr2_i)) rd_data2_o = wr_data_i;
      else                                                     rd_data2_o = regs_q[rd_addr2_i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/pipelined_decode.sv
// ID stage of the pipelined LEGv8 core: decodes one instruction per cycle into the
// ID/EX register, inserting a one-cycle bubble on load-use hazards and on EX flushes.
module pipelined_decode
  import pipelined_decode_pkg::*;
#(
  parameter int WORD     = 64,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] in_instr,
  input  logic [WORD-1:0]      in_pc,
  input  logic                 flush,
  input  logic                 wb_en,
  input  logic [REG_AW-1:0]    wb_reg,
  input  logic [WORD-1:0]      wb_data,
  output logic                 out_valid,
  output logic [WORD-1:0]      out_pc,
  output logic [OPC_W-1:0]     out_opcode,
  output logic [REG_AW-1:0]    out_rd,
  output logic [REG_AW-1:0]    out_rn,
  output logic [REG_AW-1:0]    out_rr2,
  output logic [WORD-1:0]      out_data1,
  output logic [WORD-1:0]      out_data2,
  output logic [WORD-1:0]      out_imm,
  output logic                 out_branch,
  output logic                 out_cbz,
  output logic                 out_cbnz,
  output logic                 out_mem_read,
  output logic                 out_mem_to_reg,
  output logic                 out_mem_write,
  output logic                 out_alu_src,
  output logic                 out_reg_write,
  output logic [1:0]           out_alu_op
);
  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  instr_cls_e        cls;
  logic [REG_AW-1:0] rd, rn, rr2;
  logic [WORD-1:0]   rdata1, rdata2;
  logic              hazard, load;

  logic              valid_q, valid_d;
  logic [WORD-1:0]   pc_q, pc_d, data1_q, data1_d, data2_q, data2_d, imm_q, imm_d;
  logic [OPC_W-1:0]  opcode_q, opcode_d;
  logic [REG_AW-1:0] rd_q, rd_d, rn_q, rn_d, rr2_q, rr2_d;
  ctrl_t             ctrl_q, ctrl_d;

  always_comb begin
    cls = classify(in_instr[31:21]);
    rd  = REG_AW'(in_instr[4:0]);
    rn  = REG_AW'(in_instr[9:5]);
    rr2 = rr2_is_rd(cls) ? rd : REG_AW'(in_instr[20:16]);
  end

  decode_regfile #(
    .WORD(WORD), .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr1_i(rn),
    .rd_addr2_i(rr2),
    .rd_data1_o(rdata1),
    .rd_data2_o(rdata2),
    .wr_en_i   (wb_en),
    .wr_addr_i (wb_reg),
    .wr_data_i (wb_data)
  );

  // A flush consumes the input unconditionally, so it overrides any stall.
  always_comb begin
    hazard = valid_q && ctrl_q.mem_read && (rd_q != ZR) && in_valid &&
             ((rd_q == rn) || (uses_rr2(cls) && (rd_q == rr2)));
    in_ready = flush || !hazard;
    load     = in_valid && !flush && !hazard;
  end

  always_comb begin
    valid_d  = 1'b0;
    pc_d     = '0;
    opcode_d = '0;
    rd_d     = '0;
    rn_d     = '0;
    rr2_d    = '0;
    data1_d  = '0;
    data2_d  = '0;
    imm_d    = '0;
    ctrl_d   = CTRL_ZERO;
    if (load) begin
      valid_d  = 1'b1;
      pc_d     = in_pc;
      opcode_d = in_instr[31:21];
      rd_d     = rd;
      rn_d     = rn;
      rr2_d    = rr2;
      data1_d  = rdata1;
      data2_d  = rdata2;
      imm_d    = WORD'($signed(imm_extend(in_instr, cls)));
      ctrl_d   = decode_ctrl(cls);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      opcode_q <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rr2_q    <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      imm_q    <= '0;
      ctrl_q   <= CTRL_ZERO;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      rn_q     <= rn_d;
      rr2_q    <= rr2_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      imm_q    <= imm_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = pc_q;
  assign out_opcode     = opcode_q;
  assign out_rd         = rd_q;
  assign out_rn         = rn_q;
  assign out_rr2        = rr2_q;
  assign out_data1      = data1_q;
  assign out_data2      = data2_q;
  assign out_imm        = imm_q;
  assign out_branch     = ctrl_q.branch;
  assign out_cbz        = ctrl_q.cbz;
  assign out_cbnz       = ctrl_q.cbnz;
  assign out_mem_read   = ctrl_q.mem_read;
  assign out_mem_to_reg = ctrl_q.mem_to_reg;
  assign out_mem_write  = ctrl_q.mem_write;
  assign out_alu_src    = ctrl_q.alu_src;
  assign out_reg_write  = ctrl_q.reg_write;
  assign out_alu_op     = ctrl_q.alu_op;

endmodule

// File: doc/pipelined_decode.md
# pipelined_decode

Instruction-decode stage for the pipelined LEGv8 core, replacing the single-cycle decode used by the non-pipelined datapath. Accepts one fetched instruction per cycle over a valid/ready handshake, decodes control, reads a parametrised register file with write-back bypass, and registers everything into the ID/EX pipeline register. Detects load-use hazards against its own output register (stall, bubble) and honours branch flushes from EX.

## Interface
Parameters:
- WORD, 64, datapath width (register and immediate width)
- NUM_REGS, 32, register count; must be ≤ 2^REG_AW
- REG_AW, 5, register address width
- ZERO_REG, 31, index that reads zero and ignores writes (XZR)
- BYPASS, 1, 1 = same-cycle write-back forwarded to reads; 0 = read old value

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  stage clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  WORD  PC of instruction
- flush  in  1  EX branch taken; kill in-flight ID contents
- wb_en  in  1  write-back enable
- wb_reg  in  REG_AW  write-back destination
- wb_data  in  WORD  write-back value
- out_valid  out  1  ID/EX register holds a real instruction
- out_pc  out  WORD  registered PC
- out_opcode  out  11  instr[31:21]
- out_rd, out_rn, out_rr2  out  REG_AW  destination, read-port-1 and read-port-2 indices
- out_data1, out_data2  out  WORD  register operands
- out_imm  out  WORD  extended immediate
- out_branch, out_cbz, out_cbnz, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write  out  1  control
- out_alu_op  out  2  ALU op class

## Operation
- Field split: rd=[4:0], rn=[9:5], rm=[20:16]. rr2 = rd for STUR/CBZ/CBNZ, else rm.
- Decode: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (R, alu_op 10, reg_write); ADDI 1001000100x, SUBI 1101000100x (alu_src, reg_write, alu_op 10); LDUR 11111000010 (mem_read, mem_to_reg, alu_src, reg_write, alu_op 00); STUR 11111000000 (mem_write, alu_src, alu_op 00); CBZ 10110100xxx / CBNZ 10110101xxx (cbz/cbnz, alu_op 01); B 000101xxxxx (branch). Any other opcode: all controls 0, out_valid still 1.
- Immediate: D [20:12] sign-ext; I [21:10] zero-ext; CB [23:5] sign-ext; B [25:0] sign-ext; R-type 0.
- Regfile: write on clk edge when wb_en && wb_reg != ZERO_REG && wb_reg < NUM_REGS. Read of ZERO_REG or index ≥ NUM_REGS returns 0. BYPASS=1: read address == wb_reg with valid write returns wb_data.
- Load-use hazard: out_valid && out_mem_read && out_rd != ZERO_REG && in_valid && (out_rd == rn || out_rd == rr2, rr2 compared only for R-type/STUR/CB) → in_ready=0, bubble loaded.
- Bubble: out_valid=0, all control outputs 0; data/index outputs don't-care but driven 0.
- Priority: flush > hazard > normal. Flush: in_ready=1 (input consumed and discarded), bubble loaded.

## Timing
- Reset: all outputs 0, out_valid=0, in_ready follows combinational rule (1 with no hazard), all registers 0.
- Latency 1: instruction accepted at edge N appears on out_* after edge N.
- in_ready combinational from in_valid, in_instr, output register, flush.
- Stall lasts exactly one cycle (the bubble clears the hazard); the stalled instruction must stay stable at input.
- Write-back and read of same register in same cycle: BYPASS=1 new value, BYPASS=0 old value.
- rst_n low mid-stall or mid-write: state cleared immediately, pending write lost.

## Structure
- Shared package: opcode constants, alu_op encodings, INSTR_LEN=32, control-bundle struct (ctrl_t), zero-control constant.
- Sub-module decode_regfile (2R1W, parameters WORD/NUM_REGS/REG_AW/ZERO_REG/BYPASS). Control decode and immediate extend as functions in the package.

## Test plan
- Reset then ADD X1,X2,X3 with X2=5, X3=7 preloaded via wb → next cycle out_valid=1, out_data1=5, out_data2=7, alu_op=10, reg_write=1.
- LDUR X4,[X1,#-8] then ADD X5,X4,X6 → out_imm=0xFFFF_FFFF_FFFF_FFF8; ADD sees in_ready=0 one cycle, bubble (out_valid=0), then ADD issues.
- wb_en=1 wb_reg=9 wb_data=0xABCD while decoding ORR X1,X9,X9 → BYPASS=1 both operands 0xABCD; BYPASS=0 old value.
- Write X31=0x55 then read X31 → 0; STUR reads rd as rr2; CBNZ imm -4 → out_imm=-4, cbnz=1.
- flush asserted during hazard stall → in_ready=1, out_valid=0 next cycle, no stall cycle follows.
- Illegal opcode 0x000 → out_valid=1, all control 0; rst_n pulsed mid-stream → all outputs 0 asynchronously.
